cell_pos_reader: RTL and testbench
==================================

Name: cell_pos_reader

Overview:
- Read-side sequencer for one position cell memory (single-port RAM; 2-cycle read latency; address 0 holds the particle count; addresses 1..N hold {posz, posy, posx}).
- Reads the count word, then streams the particle records to the force-evaluation / motion-update consumer over a valid/ready interface.
- Absorbs the RAM read latency with a credit-controlled output FIFO, so backpressure never loses data.
- Sits between each cell RAM and the position cache.

Parameters:
DATA_WIDTH, 96, width of one position record {posz, posy, posx}, 32 bits each
ADDR_WIDTH, 8, cell RAM address width
PARTICLE_NUM, 220, RAM depth in words; maximum legal count is PARTICLE_NUM-1
RD_LATENCY, 2, cycles from mem_rden/mem_address to valid mem_q
FIFO_DEPTH, 4, output FIFO entries; must be >= RD_LATENCY+2 for 1 record/cycle

Ports:
clock  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to read the cell; ignored unless idle
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the last record has been handed off (or count=0)
particle_count  out  ADDR_WIDTH  count latched from address 0
count_err  out  1  sticky; count read exceeded PARTICLE_NUM-1 (see Optional Feature)
mem_address  out  ADDR_WIDTH  RAM address, registered
mem_rden  out  1  RAM read enable, registered
mem_q  in  DATA_WIDTH  RAM read data
out_valid  out  1  record available
out_ready  in  1  consumer accepts the record
out_data  out  DATA_WIDTH  position record
out_id  out  ADDR_WIDTH  RAM address of the record (1..N)
out_last  out  1  high with the final record

Behaviour:
- Reset: all outputs 0; state IDLE; FIFO emptied; in-flight read pipeline cleared. Reset mid-operation discards all in-flight and buffered data, and no done is issued.
- States:
  - IDLE: start=1 -> RD_CNT.
  - RD_CNT: mem_address=0, mem_rden=1 for one cycle -> WAIT_CNT.
  - WAIT_CNT: wait RD_LATENCY; latch particle_count = mem_q[ADDR_WIDTH-1:0]. Count=0 -> DONE; otherwise -> STREAM with next_addr=1.
  - STREAM: issue a read (mem_rden=1, mem_address=next_addr, next_addr++) only when fifo_occupancy + inflight < FIFO_DEPTH. After the read of address N is issued -> DRAIN.
  - DRAIN: wait until inflight=0 and the FIFO is empty -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- mem_rden=0 in every cycle with no read; mem_address holds its last value.
- Read tracking: a valid/id shift register of length RD_LATENCY. When the tagged word emerges, it is written into the FIFO together with its id; last = (id == N).
- Output: out_valid = FIFO not empty; handshake = out_valid & out_ready. out_data, out_id and out_last are stable while out_valid=1 and out_ready=0.
- Timing (start sampled at edge 0, out_ready held 1):
  - count read in cycle 1; count latched at edge 3;
  - first particle read in cycle 4; first out_valid in cycle 7;
  - one record per cycle thereafter;
  - done in the cycle after the last handshake.
- start while busy or in DONE: ignored, no side effect.
- A FIFO push and pop in the same cycle with the FIFO full or empty is legal; the credit check guarantees the FIFO never overflows.
- count_err is cleared only by rst.

Optional Feature:
- Macro CELL_POS_READER_CLAMP_EN.
- Defined: if the latched count exceeds PARTICLE_NUM-1, particle_count = PARTICLE_NUM-1, count_err is set, and streaming proceeds with the clamped count.
- Undefined: the count is used as read; no range check; count_err is tied to 0. The consumer is responsible for rejecting bad cells.

Decomposition:
- Shared package md_cell_pkg holds:
  - position record typedef (three 32-bit fields);
  - reader state enum;
  - COUNT_ADDR = 0;
  - the DATA_WIDTH / ADDR_WIDTH defaults.
- One sub-module: pos_reader_fifo, a synchronous FIFO of FIFO_DEPTH x (DATA_WIDTH+ADDR_WIDTH+1) with occupancy output. The top level holds the FSM, the credit logic and the latency shift register.

Test Plan:
- RAM model with count=3 and records A, B, C; out_ready=1; start at cycle 0 -> out_valid cycles 7, 8, 9 with ids 1, 2, 3 and data A, B, C; out_last only at id 3; done pulses in cycle 10; busy spans cycles 1..9.
- count=0; start -> no out_valid, mem_rden never addresses 1, done pulses once, particle_count=0.
- count=10; out_ready toggled at random 50% -> all 10 records delivered in order, none duplicated; out_data stable while stalled; FIFO occupancy never exceeds 4; mem_rden throttled.
- Clamp macro defined, count=250 -> particle_count=219, count_err=1, 219 records streamed. Macro undefined -> count_err=0 and 250 reads are issued.
- rst asserted in the cycle after the 5th handshake of a count=20 run -> all outputs 0 immediately; a new start then streams from id 1 with no stale data.
- start pulsed again during STREAM -> ignored; exactly one done per accepted start.

Source files
------------

// File: rtl/md_cell_pkg.sv
// Shared types and defaults for the MD cell position memory readers.
package md_cell_pkg;

    localparam int DEFAULT_DATA_WIDTH = 96;
    localparam int DEFAULT_ADDR_WIDTH = 8;
    localparam int COUNT_ADDR         = 0;

    typedef struct packed {
        logic [31:0] posz;
        logic [31:0] posy;
        logic [31:0] posx;
    } pos_rec_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_CNT,
        ST_WAIT_CNT,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } reader_state_t;

endpackage

// File: rtl/pos_reader_fifo.sv
// First-word-fall-through FIFO buffering tagged position records; a push
// while full is accepted only when a pop frees a slot in the same cycle.
module pos_reader_fifo #(
    parameter int WIDTH = 105,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full,
    output logic [OCC_W-1:0] occupancy
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [OCC_W-1:0] occ_reg;
    logic             do_push;
    logic             do_pop;

    assign empty     = (occ_reg == '0);
    assign full      = (occ_reg == OCC_W'(DEPTH));
    assign occupancy = occ_reg;
    assign pop_data  = mem_reg[rd_ptr_reg];
    assign do_pop    = pop & ~empty;
    assign do_push   = push & (~full | do_pop);

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_reg[wr_ptr_reg] <= push_data;
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   occ_reg <= occ_reg + 1'b1;
                2'b01:   occ_reg <= occ_reg - 1'b1;
                default: occ_reg <= occ_reg;
            endcase
        end
    end

endmodule

// File: rtl/cell_pos_reader.sv
// Reads the particle count of one cell RAM, then streams its position records
// through a credit-limited FIFO. Optional count clamping: CELL_POS_READER_CLAMP_EN.
module cell_pos_reader
    import md_cell_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int PARTICLE_NUM = 220,
    parameter int RD_LATENCY   = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] particle_count,
    output logic                  count_err,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_rden,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_id,
    output logic                  out_last
);

    localparam int FW    = DATA_WIDTH + ADDR_WIDTH + 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int CW    = $clog2(FIFO_DEPTH + RD_LATENCY + 2) + 1;
    localparam int WCW   = $clog2(RD_LATENCY + 1);

    reader_state_t         state_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic [ADDR_WIDTH-1:0] count_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [ADDR_WIDTH-1:0] next_addr_reg;
    logic                  rden_reg;
    logic                  issue_vld_reg;
    logic [WCW-1:0]        wait_cnt_reg;
    logic [RD_LATENCY-1:0] pipe_vld_reg;
    logic [ADDR_WIDTH-1:0] pipe_id_reg [RD_LATENCY];

    logic [ADDR_WIDTH-1:0] count_raw;
    logic [ADDR_WIDTH-1:0] count_eff;
    logic [FW-1:0]         fifo_wr_data;
    logic [FW-1:0]         fifo_rd_data;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [OCC_W-1:0]      fifo_occ;
    logic [ADDR_WIDTH-1:0] push_id;
    logic [CW-1:0]         inflight;
    logic                  credit_ok;
    logic                  drain_done;

    assign count_raw = mem_q[ADDR_WIDTH-1:0];

`ifdef CELL_POS_READER_CLAMP_EN
    logic count_bad;
    logic count_err_reg;
    assign count_bad = (count_raw > ADDR_WIDTH'(PARTICLE_NUM - 1));
    assign count_eff = count_bad ? ADDR_WIDTH'(PARTICLE_NUM - 1) : count_raw;
    assign count_err = count_err_reg;
`else
    assign count_eff = count_raw;
    assign count_err = 1'b0;
`endif

    // Reads issued but not yet written into the FIFO, including the one on the RAM port now.
    always_comb begin
        inflight = CW'(issue_vld_reg);
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CW'(pipe_vld_reg[i]);
        end
    end

    // A pop in this cycle frees its slot at the same edge, so it is credited immediately.
    assign credit_ok  = (CW'(fifo_occ) + inflight - CW'(fifo_pop)) < CW'(FIFO_DEPTH);
    assign drain_done = (inflight == '0) && (CW'(fifo_occ) == CW'(fifo_pop));

    assign push_id      = pipe_id_reg[RD_LATENCY-1];
    assign fifo_push    = pipe_vld_reg[RD_LATENCY-1];
    assign fifo_wr_data = {mem_q, push_id, (push_id == count_reg)};
    assign fifo_pop     = out_valid & out_ready;

    assign out_valid = ~fifo_empty;
    assign {out_data, out_id, out_last} = fifo_rd_data;

    assign busy           = busy_reg;
    assign done           = done_reg;
    assign particle_count = count_reg;
    assign mem_address    = addr_reg;
    assign mem_rden       = rden_reg;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            pipe_vld_reg <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_id_reg[i] <= '0;
            end
        end else begin
            pipe_vld_reg[0] <= issue_vld_reg;
            pipe_id_reg[0]  <= addr_reg;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld_reg[i] <= pipe_vld_reg[i-1];
                pipe_id_reg[i]  <= pipe_id_reg[i-1];
            end
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            count_reg     <= '0;
            addr_reg      <= '0;
            next_addr_reg <= '0;
            rden_reg      <= 1'b0;
            issue_vld_reg <= 1'b0;
            wait_cnt_reg  <= '0;
`ifdef CELL_POS_READER_CLAMP_EN
            count_err_reg <= 1'b0;
`endif
        end else begin
            rden_reg      <= 1'b0;
            issue_vld_reg <= 1'b0;
            done_reg      <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg <= ST_RD_CNT;
                        busy_reg  <= 1'b1;
                        rden_reg  <= 1'b1;
                        addr_reg  <= ADDR_WIDTH'(COUNT_ADDR);
                    end
                end
                ST_RD_CNT: begin
                    state_reg    <= ST_WAIT_CNT;
                    wait_cnt_reg <= '0;
                end
                ST_WAIT_CNT: begin
                    if (wait_cnt_reg == WCW'(RD_LATENCY - 1)) begin
                        count_reg <= count_eff;
`ifdef CELL_POS_READER_CLAMP_EN
                        if (count_bad) begin
                            count_err_reg <= 1'b1;
                        end
`endif
                        if (count_eff == '0) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                        end else begin
                            // First record read goes out together with the count latch.
                            rden_reg      <= 1'b1;
                            issue_vld_reg <= 1'b1;
                            addr_reg      <= ADDR_WIDTH'(1);
                            next_addr_reg <= ADDR_WIDTH'(2);
                            state_reg     <= (count_eff == ADDR_WIDTH'(1)) ? ST_DRAIN : ST_STREAM;
                        end
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (credit_ok) begin
                        rden_reg      <= 1'b1;
                        issue_vld_reg <= 1'b1;
                        addr_reg      <= next_addr_reg;
                        next_addr_reg <= next_addr_reg + 1'b1;
                        if (next_addr_reg == count_reg) begin
                            state_reg <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    pos_reader_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_wr_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .occupancy (fifo_occ)
    );

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_cell_pos_reader.sv
// Directed bench for cell_pos_reader with a 2-cycle-latency cell RAM model.
module tb_cell_pos_reader;
    import md_cell_pkg::*;

    logic        clock = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [7:0]  particle_count;
    logic        count_err;
    logic [7:0]  mem_address;
    logic        mem_rden;
    logic [95:0] mem_q;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [95:0] out_data;
    logic [7:0]  out_id;
    logic        out_last;

    int vectors = 0;
    int miscompares = 0;

    logic [95:0] ram [0:255];
    logic [95:0] q_s1;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_rden) q_s1 <= ram[mem_address];
        mem_q <= q_s1;
    end

    cell_pos_reader dut (
        .clock          (clock),
        .rst            (rst),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .particle_count (particle_count),
        .count_err      (count_err),
        .mem_address    (mem_address),
        .mem_rden       (mem_rden),
        .mem_q          (mem_q),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_id         (out_id),
        .out_last       (out_last)
    );

    function automatic logic [95:0] rec(input int a);
        pos_rec_t r;
        r.posz = 32'hC000_0000 | 32'(a);
        r.posy = 32'hB000_0000 | 32'(a * 7);
        r.posx = 32'hA000_0000 | 32'(a * 3);
        return r;
    endfunction

    task automatic do_start;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clock);
        rst = 1'b1;
        #1;
        vectors++;
        if ({busy, done, particle_count, count_err, mem_address, mem_rden, out_valid, out_data, out_id, out_last} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: busy=%b done=%b cnt=%0d err=%b addr=%0d rden=%b valid=%b id=%0d last=%b, required all 0",
                     busy, done, particle_count, count_err, mem_address, mem_rden, out_valid, out_id, out_last);
        end
        @(negedge clock);
        rst = 1'b0;
        $display("reset: outputs checked");
    endtask

    task automatic test_basic_timing;
        logic exp_v;
        int   id;
        ram[0] = 96'd3;
        out_ready = 1'b1;
        do_start;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            exp_v = (k >= 7 && k <= 9);
            vectors++;
            if (out_valid !== exp_v) begin
                miscompares++;
                $display("FAIL basic_valid cycle %0d: got %b, required %b", k, out_valid, exp_v);
            end
            vectors++;
            if (busy !== (k <= 9)) begin
                miscompares++;
                $display("FAIL basic_busy cycle %0d: got %b, required %b", k, busy, (k <= 9));
            end
            vectors++;
            if (done !== (k == 10)) begin
                miscompares++;
                $display("FAIL basic_done cycle %0d: got %b, required %b", k, done, (k == 10));
            end
            if (exp_v) begin
                id = k - 6;
                vectors++;
                if (out_id !== 8'(id) || out_data !== rec(id) || out_last !== (id == 3)) begin
                    miscompares++;
                    $display("FAIL basic_record cycle %0d: id=%0d data=%h last=%b, required id=%0d data=%h last=%b",
                             k, out_id, out_data, out_last, id, rec(id), (id == 3));
                end
            end
            if (k == 1 || k == 4) begin
                vectors++;
                if (mem_rden !== 1'b1 || mem_address !== 8'(k == 4)) begin
                    miscompares++;
                    $display("FAIL basic_read cycle %0d: rden=%b addr=%0d, required rden=1 addr=%0d", k, mem_rden, mem_address, (k == 4));
                end
            end
        end
        vectors++;
        if (particle_count !== 8'd3) begin
            miscompares++;
            $display("FAIL basic_count: got %0d, required 3", particle_count);
        end
        $display("basic: count=3 timing run checked");
    endtask

    task automatic test_zero_count;
        int dones = 0;
        int valids = 0;
        int addr1 = 0;
        ram[0] = 96'd0;
        out_ready = 1'b1;
        do_start;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clock);
            if (done) dones++;
            if (out_valid) valids++;
            if (mem_rden && mem_address == 8'd1) addr1++;
        end
        vectors++;
        if (dones != 1 || valids != 0 || addr1 != 0) begin
            miscompares++;
            $display("FAIL zero_run: dones=%0d valids=%0d addr1_reads=%0d, required 1 0 0", dones, valids, addr1);
        end
        vectors++;
        if (particle_count !== 8'd0) begin
            miscompares++;
            $display("FAIL zero_count: got %0d, required 0", particle_count);
        end
        $display("zero: count=0 run checked");
    endtask

    task automatic test_backpressure;
        int          issued = 0;
        int          accepted = 0;
        int          dones = 0;
        int          k = 0;
        logic        prev_stall = 1'b0;
        logic [95:0] prev_data = '0;
        logic [7:0]  prev_id = '0;
        ram[0] = 96'd10;
        out_ready = 1'b0;
        do_start;
        while (k < 400 && dones == 0) begin
            @(negedge clock);
            k++;
            if (done) dones++;
            if (mem_rden && mem_address != 8'd0) issued++;
            if (prev_stall) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_id !== prev_id) begin
                    miscompares++;
                    $display("FAIL bp_stable cycle %0d: valid=%b id=%0d data=%h, required 1 id=%0d data=%h",
                             k, out_valid, out_id, out_data, prev_id, prev_data);
                end
            end
            if (issued - accepted > 4) begin
                vectors++;
                miscompares++;
                $display("FAIL bp_credit cycle %0d: outstanding=%0d, required <= 4", k, issued - accepted);
            end
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                accepted++;
                vectors++;
                if (out_id !== 8'(accepted) || out_data !== rec(accepted) || out_last !== (accepted == 10)) begin
                    miscompares++;
                    $display("FAIL bp_record #%0d: id=%0d data=%h last=%b, required id=%0d data=%h last=%b",
                             accepted, out_id, out_data, out_last, accepted, rec(accepted), (accepted == 10));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_id    = out_id;
        end
        vectors++;
        if (dones != 1 || accepted != 10 || issued != 10) begin
            miscompares++;
            $display("FAIL bp_totals: dones=%0d accepted=%0d reads=%0d, required 1 10 10", dones, accepted, issued);
        end
        out_ready = 1'b1;
        $display("backpressure: count=10 random-ready run checked");
    endtask

    task automatic test_clamp;
        int issued = 0;
        int accepted = 0;
        int lasts = 0;
        int dones = 0;
        int k = 0;
`ifdef CELL_POS_READER_CLAMP_EN
        int   n_exp = 219;
        logic err_exp = 1'b1;
`else
        int   n_exp = 250;
        logic err_exp = 1'b0;
`endif
        ram[0] = 96'd250;
        out_ready = 1'b1;
        do_start;
        while (k < 1000 && dones == 0) begin
            @(negedge clock);
            k++;
            if (done) dones++;
            if (mem_rden && mem_address != 8'd0) issued++;
            if (out_valid) begin
                accepted++;
                if (out_last) lasts++;
                if (out_id !== 8'(accepted) || out_data !== rec(accepted)) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL clamp_record #%0d: id=%0d, required %0d", accepted, out_id, accepted);
                end
            end
        end
        vectors++;
        if (particle_count !== 8'(n_exp) || count_err !== err_exp) begin
            miscompares++;
            $display("FAIL clamp_count: cnt=%0d err=%b, required %0d %b", particle_count, count_err, n_exp, err_exp);
        end
        vectors++;
        if (dones != 1 || accepted != n_exp || issued != n_exp || lasts != 1) begin
            miscompares++;
            $display("FAIL clamp_totals: dones=%0d records=%0d reads=%0d lasts=%0d, required 1 %0d %0d 1",
                     dones, accepted, issued, lasts, n_exp, n_exp);
        end
        $display("clamp: count=250 run checked, expected %0d records", n_exp);
    endtask

    task automatic test_reset_mid;
        int hs = 0;
        int k = 0;
        int dones = 0;
        ram[0] = 96'd20;
        out_ready = 1'b1;
        do_start;
        while (k < 200 && hs < 5) begin
            @(negedge clock);
            k++;
            if (out_valid && out_ready) hs++;
        end
        @(posedge clock);
        @(negedge clock);
        rst = 1'b1;
        #1;
        vectors++;
        if ({busy, done, particle_count, count_err, mem_address, mem_rden, out_valid, out_data, out_id, out_last} !== '0 || hs != 5) begin
            miscompares++;
            $display("FAIL midrst_outputs: hs=%0d busy=%b done=%b cnt=%0d valid=%b rden=%b id=%0d, required 5 handshakes and all 0",
                     hs, busy, done, particle_count, out_valid, mem_rden, out_id);
        end
        @(negedge clock);
        rst = 1'b0;
        do_start;
        hs = 0;
        k = 0;
        while (k < 200 && dones == 0) begin
            @(negedge clock);
            k++;
            if (done) dones++;
            if (out_valid) begin
                hs++;
                if (hs == 1 || out_id !== 8'(hs) || out_data !== rec(hs)) begin
                    vectors++;
                    if (out_id !== 8'(hs) || out_data !== rec(hs)) begin
                        miscompares++;
                        $display("FAIL midrst_record #%0d: id=%0d data=%h, required id=%0d data=%h", hs, out_id, out_data, hs, rec(hs));
                    end
                end
            end
        end
        vectors++;
        if (dones != 1 || hs != 20) begin
            miscompares++;
            $display("FAIL midrst_totals: dones=%0d records=%0d, required 1 20", dones, hs);
        end
        $display("reset_mid: restart after mid-run reset checked");
    endtask

    task automatic test_start_ignored;
        int hs = 0;
        int dones = 0;
        int busy_after = 0;
        int reads_after = 0;
        ram[0] = 96'd5;
        out_ready = 1'b1;
        do_start;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clock);
            start = 1'b0;
            if (dones > 0 && k > 0) begin
                if (busy) busy_after++;
                if (mem_rden) reads_after++;
            end
            if (done) begin
                dones++;
                start = 1'b1;
            end
            if (k == 5 || k == 8) start = 1'b1;
            if (out_valid) begin
                hs++;
                vectors++;
                if (out_id !== 8'(hs) || out_data !== rec(hs) || out_last !== (hs == 5)) begin
                    miscompares++;
                    $display("FAIL ignore_record #%0d: id=%0d last=%b, required id=%0d last=%b", hs, out_id, out_last, hs, (hs == 5));
                end
            end
        end
        start = 1'b0;
        vectors++;
        if (dones != 1 || hs != 5 || busy_after != 0 || reads_after != 0) begin
            miscompares++;
            $display("FAIL ignore_totals: dones=%0d records=%0d busy_after=%0d reads_after=%0d, required 1 5 0 0",
                     dones, hs, busy_after, reads_after);
        end
        $display("start_ignored: extra starts during stream and done checked");
    endtask

    initial begin
        for (int a = 0; a < 256; a++) ram[a] = rec(a);
        q_s1 = '0;
        mem_q = '0;
        test_reset;
        test_basic_timing;
        test_zero_count;
        test_backpressure;
        test_start_ignored;
        test_clamp;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
